n64adv_osd_wr_sched: RTL and testbench

Write-port scheduler for the OSD text/colour RAM. It shares the single RAM write port between two requesters:
- the NIOS-side write vector, buffered in a small FIFO;
- a hardware fill engine that clears or paints the whole OSD window at one word per granted cycle.

It sits between the NIOS PIO exports (wrctrl/wraddr/wrdata) and the OSD RAM write port in the CLK_25M domain. It drives one packed 25-bit write vector plus a write enable.

---
 rtl/n64adv_osd_pkg.sv | 29 ++
 rtl/n64adv_osd_wr_fifo.sv | 57 +++++
 rtl/n64adv_osd_wr_sched.sv | 154 +++++++++++++++
 tb/tb_n64adv_osd_wr_sched.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/n64adv_osd_pkg.sv
// n64adv_osd_pkg
//   Shared definitions for the OSD RAM write-port scheduler:
//   - default field widths of the packed write vector {ctrl, addr, data}
//   - bit offsets of each field inside that vector
//   - fill-engine FSM state type
//   - encoding of the round-robin "last grant" flag
package n64adv_osd_pkg;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 13;
  localparam int CTRL_W = 2;
  localparam int VEC_W  = CTRL_W + ADDR_W + DATA_W;  // 25

  // Field offsets inside the packed vector (data occupies the LSBs).
  localparam int DATA_LSB = 0;
  localparam int ADDR_LSB = DATA_W;
  localparam int CTRL_LSB = DATA_W + ADDR_W;

  typedef enum logic [1:0] {
    FILL_IDLE = 2'd0,
    FILL_RUN  = 2'd1,
    FILL_DONE = 2'd2
  } fill_state_t;

  // Round-robin history: which requester owned the most recent write slot.
  localparam logic GNT_CPU  = 1'b0;
  localparam logic GNT_FILL = 1'b1;

endpackage

// File: rtl/n64adv_osd_wr_fifo.sv
// n64adv_osd_wr_fifo
//   Small synchronous FIFO buffering CPU write vectors.
//   Ports:
//     i_clk    clock
//     i_rst    synchronous active-high flush
//     i_push   write i_data (ignored while full)
//     i_data   entry to store
//     i_pop    drop the head entry (ignored while empty)
//     o_data   head entry, valid whenever o_empty is low
//     o_full   DEPTH entries stored
//     o_empty  no entries stored
module n64adv_osd_wr_fifo #(
  parameter int WIDTH = 25,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  // One extra pointer bit tells a full buffer apart from an empty one.
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_data  = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/n64adv_osd_wr_sched.sv
// n64adv_osd_wr_sched
//   Shares the single OSD RAM write port between the buffered NIOS write
//   vector and a hardware fill engine that writes every address 0..FILL_LAST.
//   Contention is resolved round-robin so each side gets every other slot.
//   Ports:
//     CLK_25M       system clock
//     RST           synchronous active-high reset (flushes FIFO, aborts fill)
//     CPU_WrVector  {wrctrl, wraddr, wrdata} sampled with CPU_WrReq
//     CPU_WrReq     one-cycle write request
//     CPU_WrReady   FIFO not full
//     FILL_Start    one-cycle fill start pulse (ignored unless idle)
//     FILL_Ctrl     plane enables used for all fill writes
//     FILL_Data     word written by the fill
//     FILL_Busy     fill FSM in RUN or DONE
//     FILL_Done     one-cycle pulse, the cycle after the last fill write strobe
//     OSD_WrVector  registered write vector to the RAM
//     OSD_WrEn      registered write strobe
module n64adv_osd_wr_sched #(
  parameter int              ADDR_W     = n64adv_osd_pkg::ADDR_W,
  parameter int              DATA_W     = n64adv_osd_pkg::DATA_W,
  parameter int              CTRL_W     = n64adv_osd_pkg::CTRL_W,
  parameter int              FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] FILL_LAST = 10'd767
) (
  input  logic                             CLK_25M,
  input  logic                             RST,
  input  logic [CTRL_W+ADDR_W+DATA_W-1:0]  CPU_WrVector,
  input  logic                             CPU_WrReq,
  output logic                             CPU_WrReady,
  input  logic                             FILL_Start,
  input  logic [CTRL_W-1:0]                FILL_Ctrl,
  input  logic [DATA_W-1:0]                FILL_Data,
  output logic                             FILL_Busy,
  output logic                             FILL_Done,
  output logic [CTRL_W+ADDR_W+DATA_W-1:0]  OSD_WrVector,
  output logic                             OSD_WrEn
);

  import n64adv_osd_pkg::*;

  localparam int W_VEC    = CTRL_W + ADDR_W + DATA_W;
  localparam int CTRL_OFS = DATA_W + ADDR_W;

  // ---------------------------------------------------------------- CPU path
  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic [W_VEC-1:0] w_fifo_data;
  logic             w_cpu_push;
  logic             w_gnt_cpu;
  logic             w_gnt_fill;

  // A request with no plane enabled would be a no-op write; drop it here
  // instead of spending a RAM slot on it.
  assign w_cpu_push  = CPU_WrReq & ~w_fifo_full & (|CPU_WrVector[CTRL_OFS +: CTRL_W]);
  assign CPU_WrReady = ~w_fifo_full;

  n64adv_osd_wr_fifo #(
    .WIDTH (W_VEC),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (CLK_25M),
    .i_rst   (RST),
    .i_push  (w_cpu_push),
    .i_data  (CPU_WrVector),
    .i_pop   (w_gnt_cpu),
    .o_data  (w_fifo_data),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  // --------------------------------------------------------------- fill FSM
  fill_state_t       r_state;
  fill_state_t       w_state_next;
  logic              w_fill_load;
  logic [ADDR_W-1:0] r_fill_addr;
  logic [CTRL_W-1:0] r_fill_ctrl;
  logic [DATA_W-1:0] r_fill_data;
  logic              r_fill_done;

  always_comb begin
    w_state_next = r_state;
    w_fill_load  = 1'b0;
    case (r_state)
      FILL_IDLE: begin
        if (FILL_Start) begin
          w_state_next = FILL_RUN;
          w_fill_load  = 1'b1;
        end
      end
      FILL_RUN: begin
        // Leave only once the last address has actually won a slot.
        if (w_gnt_fill && (r_fill_addr == FILL_LAST)) w_state_next = FILL_DONE;
      end
      FILL_DONE: w_state_next = FILL_IDLE;
      default:   w_state_next = FILL_IDLE;
    endcase
  end

  assign FILL_Busy = (r_state != FILL_IDLE);
  assign FILL_Done = r_fill_done;

  // ------------------------------------------------------------- arbitration
  logic w_cpu_req;
  logic w_fill_req;
  logic r_last_grant;

  assign w_cpu_req  = ~w_fifo_empty;
  assign w_fill_req = (r_state == FILL_RUN);
  // Under contention the side that did not own the previous slot wins.
  assign w_gnt_cpu  = w_cpu_req  & (~w_fill_req | (r_last_grant == GNT_FILL));
  assign w_gnt_fill = w_fill_req & (~w_cpu_req  | (r_last_grant == GNT_CPU));

  // ------------------------------------------------------------- registers
  logic [W_VEC-1:0] r_wr_vec;
  logic             r_wr_en;

  always_ff @(posedge CLK_25M) begin
    if (RST) begin
      r_state      <= FILL_IDLE;
      r_fill_addr  <= '0;
      r_fill_ctrl  <= '0;
      r_fill_data  <= '0;
      r_fill_done  <= 1'b0;
      r_last_grant <= GNT_FILL;
      r_wr_en      <= 1'b0;
      r_wr_vec     <= '0;
    end else begin
      r_state <= w_state_next;

      if (w_fill_load) begin
        r_fill_ctrl <= FILL_Ctrl;
        r_fill_data <= FILL_Data;
        r_fill_addr <= '0;
      end else if (w_gnt_fill) begin
        r_fill_addr <= r_fill_addr + 1'b1;
      end

      // DONE is entered together with the last write strobe; the pulse is
      // delayed one cycle so it follows that strobe.
      r_fill_done <= (r_state == FILL_DONE);

      if (w_gnt_cpu)       r_last_grant <= GNT_CPU;
      else if (w_gnt_fill) r_last_grant <= GNT_FILL;

      r_wr_en <= w_gnt_cpu | w_gnt_fill;
      if (w_gnt_cpu)       r_wr_vec <= w_fifo_data;
      else if (w_gnt_fill) r_wr_vec <= {r_fill_ctrl, r_fill_addr, r_fill_data};
    end
  end

  assign OSD_WrVector = r_wr_vec;
  assign OSD_WrEn     = r_wr_en;

endmodule

// File: tb/tb_n64adv_osd_wr_sched.sv
// tb_n64adv_osd_wr_sched
//   Directed bench for the OSD write-port scheduler. A passive monitor logs
//   every write strobe with the index of the clock edge that produced it;
//   the directed sequence compares outputs and the log against hand-derived
//   values.
module tb_n64adv_osd_wr_sched;

  import n64adv_osd_pkg::*;

  localparam int VW = VEC_W;

  logic          CLK_25M = 1'b0;
  logic          RST = 1'b1;
  logic [VW-1:0] CPU_WrVector = '0;
  logic          CPU_WrReq = 1'b0;
  logic          CPU_WrReady;
  logic          FILL_Start = 1'b0;
  logic [1:0]    FILL_Ctrl = '0;
  logic [12:0]   FILL_Data = '0;
  logic          FILL_Busy;
  logic          FILL_Done;
  logic [VW-1:0] OSD_WrVector;
  logic          OSD_WrEn;

  n64adv_osd_wr_sched #(
    .ADDR_W     (10),
    .DATA_W     (13),
    .CTRL_W     (2),
    .FIFO_DEPTH (4),
    .FILL_LAST  (10'd767)
  ) dut (
    .CLK_25M      (CLK_25M),
    .RST          (RST),
    .CPU_WrVector (CPU_WrVector),
    .CPU_WrReq    (CPU_WrReq),
    .CPU_WrReady  (CPU_WrReady),
    .FILL_Start   (FILL_Start),
    .FILL_Ctrl    (FILL_Ctrl),
    .FILL_Data    (FILL_Data),
    .FILL_Busy    (FILL_Busy),
    .FILL_Done    (FILL_Done),
    .OSD_WrVector (OSD_WrVector),
    .OSD_WrEn     (OSD_WrEn)
  );

  always #5 CLK_25M = ~CLK_25M;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge CLK_25M) cyc <= cyc + 1;

  int            log_cyc[$];
  logic [VW-1:0] log_vec[$];

  always @(negedge CLK_25M) begin
    if (OSD_WrEn) begin
      log_cyc.push_back(cyc);
      log_vec.push_back(OSD_WrVector);
    end
  end

  task automatic tick();
    @(posedge CLK_25M);
    #1;
  endtask

  task automatic clear_log();
    log_cyc.delete();
    log_vec.delete();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [VW-1:0] mkvec(input logic [1:0] c, input logic [9:0] a,
                                          input logic [12:0] d);
    return {c, a, d};
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int            t0, tr, nfill, ncpu, errs, seqerr, nlog, n;
    logic [VW-1:0] v, ev;
    logic [VW-1:0] dvec [3];
    logic [VW-1:0] evec [8];

    // ---------------- reset values
    tick(); tick();
    chk("rst_ready", CPU_WrReady, 1);
    chk("rst_busy",  FILL_Busy, 0);
    chk("rst_done",  FILL_Done, 0);
    chk("rst_wren",  OSD_WrEn, 0);
    chk("rst_vec",   OSD_WrVector, 0);
    RST = 1'b0;
    tick();

    // ---------------- single CPU write, 2-cycle latency
    clear_log();
    ev = mkvec(2'b11, 10'h005, 13'h1A5);
    CPU_WrVector = ev; CPU_WrReq = 1'b1;
    tick();
    CPU_WrReq = 1'b0; CPU_WrVector = '0;
    chk("a_wren_early", OSD_WrEn, 0);
    tick();
    chk("a_wren", OSD_WrEn, 1);
    chk("a_vec", OSD_WrVector, ev);
    tick();
    chk("a_wren_off", OSD_WrEn, 0);
    chk("a_vec_hold", OSD_WrVector, ev);
    chk("a_count", log_vec.size(), 1);
    $display("[TB] single write done");

    // ---------------- five back-to-back writes, no fill: drain every cycle
    clear_log();
    t0 = cyc + 1;
    for (int k = 0; k < 5; k++) begin
      chk("b_ready", CPU_WrReady, 1);
      CPU_WrVector = mkvec(2'b01, 10'(k + 16), 13'(k * 3 + 7));
      CPU_WrReq = 1'b1;
      tick();
    end
    CPU_WrReq = 1'b0;
    repeat (4) tick();
    chk("b_count", log_vec.size(), 5);
    for (int k = 0; k < 5 && k < log_vec.size(); k++) begin
      chk("b_vec", log_vec[k], mkvec(2'b01, 10'(k + 16), 13'(k * 3 + 7)));
      chk("b_cyc", log_cyc[k], t0 + 1 + k);
    end
    $display("[TB] back-to-back writes done");

    // ---------------- wrctrl == 0 request is dropped
    clear_log();
    CPU_WrVector = mkvec(2'b00, 10'h3FF, 13'h1FFF); CPU_WrReq = 1'b1;
    tick();
    CPU_WrReq = 1'b0;
    chk("z_ready", CPU_WrReady, 1);
    repeat (3) tick();
    chk("z_count", log_vec.size(), 0);
    chk("z_wren", OSD_WrEn, 0);
    $display("[TB] zero-ctrl drop done");

    // ---------------- uncontended fill, with an ignored restart mid-run
    clear_log();
    FILL_Ctrl = 2'b11; FILL_Data = 13'h0000; FILL_Start = 1'b1;
    t0 = cyc + 1;
    tick();
    FILL_Start = 1'b0; FILL_Ctrl = 2'b01; FILL_Data = 13'h1555;
    chk("c_busy", FILL_Busy, 1);
    chk("c_wren_early", OSD_WrEn, 0);
    for (int i = 0; i < 768; i++) begin
      if (i == 100) FILL_Start = 1'b1;
      tick();
      FILL_Start = 1'b0;
      chk("c_word", {OSD_WrEn, OSD_WrVector}, {1'b1, mkvec(2'b11, 10'(i), 13'h0000)});
    end
    chk("c_busy_last", FILL_Busy, 1);
    chk("c_done_early", FILL_Done, 0);
    tick();
    chk("c_done", FILL_Done, 1);
    chk("c_done_cyc", cyc - t0, 769);
    chk("c_busy_off", FILL_Busy, 0);
    chk("c_wren_off", OSD_WrEn, 0);
    tick();
    chk("c_done_pulse", FILL_Done, 0);
    chk("c_count", log_vec.size(), 768);
    $display("[TB] uncontended fill done");

    // ---------------- fill contended by a 3-write CPU burst
    clear_log();
    FILL_Ctrl = 2'b01; FILL_Data = 13'h0ABC; FILL_Start = 1'b1;
    t0 = cyc + 1;
    tick();
    FILL_Start = 1'b0;
    repeat (20) tick();
    tr = cyc + 1;
    for (int k = 0; k < 3; k++) begin
      dvec[k] = mkvec(2'b10, 10'(k + 'h40), 13'(k + 'h1000));
      CPU_WrVector = dvec[k]; CPU_WrReq = 1'b1;
      tick();
    end
    CPU_WrReq = 1'b0;
    n = 0;
    while (n < 2000 && !FILL_Done) begin tick(); n++; end
    chk("d_done_seen", FILL_Done, 1);
    chk("d_done_cyc", cyc - t0, 772);
    nfill = 0; ncpu = 0; errs = 0; seqerr = 0;
    for (int j = 0; j < log_vec.size(); j++) begin
      v = log_vec[j];
      if (log_cyc[j] != t0 + 1 + j) seqerr++;
      if (v[CTRL_LSB +: CTRL_W] == 2'b01) begin
        if (v[ADDR_LSB +: ADDR_W] != 10'(nfill) || v[DATA_LSB +: DATA_W] != 13'h0ABC) errs++;
        nfill++;
      end else begin
        if (ncpu >= 3 || v != dvec[ncpu] || log_cyc[j] != tr + 1 + 2 * ncpu) errs++;
        ncpu++;
      end
    end
    chk("d_fill_count", nfill, 768);
    chk("d_cpu_count", ncpu, 3);
    chk("d_order_err", errs, 0);
    chk("d_slot_gaps", seqerr, 0);
    chk("d_total", log_vec.size(), 771);
    tick();
    $display("[TB] contended fill done");

    // ---------------- FIFO fills up while sharing slots with a fill
    clear_log();
    FILL_Ctrl = 2'b01; FILL_Data = 13'h0000; FILL_Start = 1'b1;
    tick();
    FILL_Start = 1'b0;
    repeat (10) tick();
    for (int k = 0; k < 8; k++) begin
      chk("e_ready", CPU_WrReady, (k < 7) ? 1 : 0);
      evec[k] = mkvec(2'b10, 10'(k + 'h80), 13'(k + 'h200));
      CPU_WrVector = evec[k]; CPU_WrReq = 1'b1;
      tick();
    end
    CPU_WrReq = 1'b0;
    repeat (20) tick();
    ncpu = 0; errs = 0;
    for (int j = 0; j < log_vec.size(); j++) begin
      v = log_vec[j];
      if (v[CTRL_LSB +: CTRL_W] == 2'b10) begin
        if (ncpu >= 7 || v != evec[ncpu]) errs++;
        ncpu++;
      end
    end
    chk("e_cpu_count", ncpu, 7);
    chk("e_order_err", errs, 0);
    n = 0;
    while (n < 50 && !CPU_WrReady) begin tick(); n++; end
    chk("e_ready_again", CPU_WrReady, 1);
    CPU_WrVector = evec[7]; CPU_WrReq = 1'b1;
    tick();
    CPU_WrReq = 1'b0;
    repeat (6) tick();
    ncpu = 0;
    v = '0;
    for (int j = 0; j < log_vec.size(); j++) begin
      if (log_vec[j][CTRL_LSB +: CTRL_W] == 2'b10) begin
        ncpu++;
        v = log_vec[j];
      end
    end
    chk("e_cpu_count_re", ncpu, 8);
    chk("e_last_vec", v, evec[7]);
    n = 0;
    while (n < 2000 && !FILL_Done) begin tick(); n++; end
    chk("e_done_seen", FILL_Done, 1);
    tick();
    $display("[TB] fifo full handling done");

    // ---------------- reset mid-fill with two writes queued
    clear_log();
    FILL_Ctrl = 2'b11; FILL_Data = 13'h0F0F; FILL_Start = 1'b1;
    tick();
    FILL_Start = 1'b0;
    repeat (298) tick();
    for (int k = 0; k < 3; k++) begin
      CPU_WrVector = mkvec(2'b10, 10'(k + 'h100), 13'(k + 'h300)); CPU_WrReq = 1'b1;
      tick();
    end
    CPU_WrReq = 1'b0;
    RST = 1'b1;
    tick();
    chk("g_wren", OSD_WrEn, 0);
    chk("g_busy", FILL_Busy, 0);
    chk("g_ready", CPU_WrReady, 1);
    chk("g_done", FILL_Done, 0);
    chk("g_vec", OSD_WrVector, 0);
    RST = 1'b0;
    nlog = log_vec.size();
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("g_done_after", FILL_Done, 0);
      chk("g_wren_after", OSD_WrEn, 0);
    end
    chk("g_no_writes", log_vec.size(), nlog);
    $display("[TB] reset mid-fill done");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
